// File: rtl/link_test_sequencer.sv
// BER test controller for the Hamming link: resets the link, enables the PN source,
// self-synchronises a local PN checker on the decoded stream and counts bit errors.
module link_test_sequencer #(
    parameter int unsigned         PN_WIDTH     = 7,
    parameter logic [PN_WIDTH-1:0] PN_TAPS      = 7'b1100000,
    parameter int unsigned         RST_CYCLES   = 4,
    parameter int unsigned         SYNC_TIMEOUT = 1024,
    parameter int unsigned         LOCK_BITS    = 32,
    parameter int unsigned         MEAS_BITS    = 4096,
    parameter int unsigned         MAX_ERR      = 0,
    parameter int unsigned         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             frame_sync,
    input  logic             rx_valid,
    input  logic             rx_bit,
    output logic             link_rst,
    output logic             pn_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             sync_lost,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LRST      = 3'd1,
        S_WAIT_SYNC = 3'd2,
        S_SEED      = 3'd3,
        S_LOCK      = 3'd4,
        S_MEASURE   = 3'd5,
        S_DONE      = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]    seed_cnt_q, seed_cnt_d;
    logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [PN_WIDTH-1:0] chk_q, chk_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic                sync_lost_q, sync_lost_d;
    logic                done_q, done_d;

    logic pred;
    logic acquiring;
    logic to_expired;

    assign pred       = ^(chk_q & PN_TAPS);
    assign acquiring  = (state_q == S_WAIT_SYNC) || (state_q == S_SEED) || (state_q == S_LOCK);
    assign to_expired = (to_cnt_q == CNT_W'(SYNC_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            seed_cnt_q  <= '0;
            lock_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            chk_q       <= '0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            sync_lost_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            seed_cnt_q  <= seed_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            chk_q       <= chk_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            sync_lost_q <= sync_lost_d;
            done_q      <= done_d;
        end
    end

    // Branch order encodes the priority abort > timeout > sync loss > normal flow.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        to_cnt_d    = to_cnt_q;
        seed_cnt_d  = seed_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        chk_d       = chk_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        sync_lost_d = sync_lost_q;
        done_d      = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pass_d  = 1'b0;
        end else if (acquiring && to_expired) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
            pass_d    = 1'b0;
            done_d    = 1'b1;
        end else if ((state_q == S_MEASURE) && !frame_sync) begin
            state_d     = S_DONE;
            sync_lost_d = 1'b1;
            pass_d      = 1'b0;
            done_d      = 1'b1;
        end else begin
            if (acquiring) to_cnt_d = to_cnt_q + ONE;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_LRST;
                        rst_cnt_d   = '0;
                        to_cnt_d    = '0;
                        seed_cnt_d  = '0;
                        lock_cnt_d  = '0;
                        bit_cnt_d   = '0;
                        err_cnt_d   = '0;
                        chk_d       = '0;
                        pass_d      = 1'b0;
                        timeout_d   = 1'b0;
                        sync_lost_d = 1'b0;
                    end
                end
                S_LRST: begin
                    if (rst_cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_d  = S_WAIT_SYNC;
                        to_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + ONE;
                    end
                end
                S_WAIT_SYNC: begin
                    if (frame_sync) state_d = S_SEED;
                end
                S_SEED: begin
                    if (rx_valid) begin
                        chk_d      = {chk_q[PN_WIDTH-2:0], rx_bit};
                        seed_cnt_d = seed_cnt_q + ONE;
                        if (seed_cnt_q == CNT_W'(PN_WIDTH - 1)) state_d = S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (rx_valid) begin
                        chk_d = {chk_q[PN_WIDTH-2:0], rx_bit};
                        if (rx_bit == pred) begin
                            lock_cnt_d = lock_cnt_q + ONE;
                            if (lock_cnt_q == CNT_W'(LOCK_BITS - 1)) state_d = S_MEASURE;
                        end else begin
                            lock_cnt_d = '0;
                        end
                    end
                end
                S_MEASURE: begin
                    if (rx_valid) begin
                        chk_d     = {chk_q[PN_WIDTH-2:0], pred};
                        bit_cnt_d = bit_cnt_q + ONE;
                        if ((rx_bit != pred) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ONE;
                        if (bit_cnt_q == CNT_W'(MEAS_BITS - 1)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            pass_d  = (err_cnt_d <= CNT_W'(MAX_ERR)) && !timeout_q && !sync_lost_q;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // abort gates the link controls in the same cycle it is raised.
    always_comb begin
        busy     = 1'b0;
        link_rst = 1'b0;
        pn_en    = 1'b0;
        unique case (state_q)
            S_LRST: begin
                busy     = 1'b1;
                link_rst = !abort;
            end
            S_WAIT_SYNC, S_SEED, S_LOCK, S_MEASURE: begin
                busy  = 1'b1;
                pn_en = !abort;
            end
            default: ;
        endcase
    end

    assign state     = state_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign sync_lost = sync_lost_q;
    assign bit_count = bit_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_link_test_sequencer.sv
// Bench for link_test_sequencer: emulated PN link with random valid gaps, stream-level
// reference model checked every cycle, plus literal end-of-test expectations.
module tb_link_test_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic        frame_sync = 1'b0, rx_valid = 1'b0, rx_bit = 1'b0;
    logic        link_rst, pn_en, busy, done, pass, timeout, sync_lost;
    logic [2:0]  state;
    logic [15:0] bit_count, err_count;
    logic        link_rst3, pn_en3, busy3, done3, pass3, timeout3, sync_lost3;
    logic [2:0]  state3;
    logic [15:0] bit_count3, err_count3;

    always #5 clk = ~clk;

    link_test_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_sync(frame_sync),
        .rx_valid(rx_valid), .rx_bit(rx_bit), .link_rst(link_rst), .pn_en(pn_en),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .sync_lost(sync_lost),
        .state(state), .bit_count(bit_count), .err_count(err_count)
    );

    link_test_sequencer #(.MAX_ERR(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_sync(frame_sync),
        .rx_valid(rx_valid), .rx_bit(rx_bit), .link_rst(link_rst3), .pn_en(pn_en3),
        .busy(busy3), .done(done3), .pass(pass3), .timeout(timeout3), .sync_lost(sync_lost3),
        .state(state3), .bit_count(bit_count3), .err_count(err_count3)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase numbers are the published state codes; the checker is a
    // history of bits where the prediction is (7 bits ago) xor (6 bits ago).
    int m_phase = 0, m_rst_left = 0, m_tcnt = 0, m_seeded = 0, m_run = 0;
    int m_bits = 0, m_err = 0;
    bit m_pass = 0, m_pass3 = 0, m_timeout = 0, m_slost = 0, m_done = 0;
    bit hist[$];

    function automatic bit hist_pred();
        return hist[hist.size()-7] ^ hist[hist.size()-6];
    endfunction

    task automatic hist_clear();
        hist.delete();
        for (int i = 0; i < 7; i++) hist.push_back(1'b0);
    endtask

    task automatic hist_push(input bit b);
        hist.push_back(b);
        if (hist.size() > 16) void'(hist.pop_front());
    endtask

    task automatic model_finish(input bit ok);
        m_phase = 6;
        m_done  = 1;
        m_pass  = ok && (m_err <= 0);
        m_pass3 = ok && (m_err <= 3);
    endtask

    always @(posedge clk) begin
        bit p;
        m_done = 0;
        if (rst) begin
            m_phase = 0; m_rst_left = 0; m_tcnt = 0; m_seeded = 0; m_run = 0;
            m_bits = 0; m_err = 0; m_pass = 0; m_pass3 = 0; m_timeout = 0; m_slost = 0;
            hist_clear();
        end else if (abort && m_phase != 0) begin
            m_phase = 0; m_pass = 0; m_pass3 = 0;
        end else if (m_phase >= 2 && m_phase <= 4 && m_tcnt == 1023) begin
            m_timeout = 1;
            model_finish(1'b0);
        end else if (m_phase == 5 && !frame_sync) begin
            m_slost = 1;
            model_finish(1'b0);
        end else begin
            if (m_phase >= 2 && m_phase <= 4) m_tcnt++;
            case (m_phase)
                0, 6: if (start) begin
                    m_phase = 1; m_rst_left = 4; m_tcnt = 0; m_seeded = 0; m_run = 0;
                    m_bits = 0; m_err = 0; m_pass = 0; m_pass3 = 0; m_timeout = 0; m_slost = 0;
                    hist_clear();
                end
                1: begin
                    m_rst_left--;
                    if (m_rst_left == 0) begin m_phase = 2; m_tcnt = 0; end
                end
                2: if (frame_sync) m_phase = 3;
                3: if (rx_valid) begin
                    hist_push(rx_bit);
                    m_seeded++;
                    if (m_seeded == 7) begin m_phase = 4; m_run = 0; end
                end
                4: if (rx_valid) begin
                    p = hist_pred();
                    m_run = (rx_bit == p) ? m_run + 1 : 0;
                    hist_push(rx_bit);
                    if (m_run == 32) m_phase = 5;
                end
                5: if (rx_valid) begin
                    p = hist_pred();
                    hist_push(p);
                    m_bits++;
                    if (rx_bit != p && m_err < 65535) m_err++;
                    if (m_bits == 4096) model_finish(1'b1);
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        bit ex_busy, ex_lrst, ex_pn;
        if (chk_en) begin
            ex_busy = (m_phase >= 1 && m_phase <= 5);
            ex_lrst = (m_phase == 1) && !abort;
            ex_pn   = (m_phase >= 2 && m_phase <= 5) && !abort;
            check("cycle{state,busy,lrst,pn,done,pass,to,sl,pass3,bits,errs}",
                  64'({state, busy, link_rst, pn_en, done, pass, timeout, sync_lost, pass3,
                       bit_count, err_count}),
                  64'({3'(m_phase), ex_busy, ex_lrst, ex_pn, m_done, m_pass, m_timeout, m_slost,
                       m_pass3, 16'(m_bits), 16'(m_err)}));
        end
    end

    // Link emulation: PN source advancing once per valid bit.
    logic [6:0] pn_q = 7'h5a;
    bit fs_hold_low = 0;
    int fs_delay = 10, drop_at = -1, abort_at = -1, lock_err_run = -1;
    int flips[$];
    int cnt_lrst, cnt_wait, cnt_done, lock_gap;

    task automatic pn_step(output logic b);
        b    = pn_q[6] ^ pn_q[5];
        pn_q = {pn_q[5:0], b};
    endtask

    task automatic run_link(input int max_cycles);
        int  cycles = 0;
        int  fs_cnt = 0;
        int  after = 0;
        bit  flipped_lock = 0;
        logic b;
        cnt_lrst = 0; cnt_wait = 0; cnt_done = 0; lock_gap = -1;
        while (cycles < max_cycles) begin
            start = (cycles == 0) ||
                    (m_phase >= 1 && m_phase <= 5 && $urandom_range(15, 0) == 0);
            abort = 0; frame_sync = 0; rx_valid = 0; rx_bit = 0;
            if (m_phase >= 2 && m_phase <= 5) begin
                fs_cnt++;
                frame_sync = !fs_hold_low && (fs_cnt > fs_delay);
                if (m_phase == 5 && m_bits == drop_at) frame_sync = 0;
                if (m_phase == 5 && m_bits == abort_at) abort = 1;
                rx_valid = ($urandom_range(3, 0) != 0);
                if (rx_valid) begin
                    pn_step(b);
                    rx_bit = b;
                    if (m_phase == 5)
                        foreach (flips[i]) if (flips[i] == m_bits) rx_bit = !rx_bit;
                    if (m_phase == 4 && !flipped_lock && m_run == lock_err_run) begin
                        rx_bit = !rx_bit;
                        flipped_lock = 1;
                    end else if (flipped_lock) begin
                        after++;
                    end
                end
            end
            @(posedge clk); #1;
            cycles++;
            if (link_rst) cnt_lrst++;
            if (state == 3'd2) cnt_wait++;
            if (done) cnt_done++;
            if (flipped_lock && lock_gap < 0 && state == 3'd5) lock_gap = after;
            if (m_phase == 0 || m_phase == 6) break;
        end
        start = 0; abort = 0; frame_sync = 0; rx_valid = 0; rx_bit = 0;
        check("run_bound", 64'(cycles < max_cycles), 64'(1));
    endtask

    task automatic set_default();
        fs_hold_low = 0; fs_delay = $urandom_range(40, 3);
        drop_at = -1; abort_at = -1; lock_err_run = -1;
        flips.delete();
    endtask

    initial begin
        rst = 1;
        @(posedge clk); #1;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("reset_state", 64'(state), 64'(0));
        check("reset_flags", 64'({busy, link_rst, pn_en, done, pass, timeout, sync_lost}), 64'(0));
        check("reset_counts", 64'({bit_count, err_count}), 64'(0));

        // clean link
        set_default();
        run_link(8000);
        check("t1_lrst_cycles", 64'(cnt_lrst), 64'(4));
        check("t1_done_pulses", 64'(cnt_done), 64'(1));
        check("t1_bits_errs", 64'({bit_count, err_count}), 64'({16'd4096, 16'd0}));
        check("t1_pass", 64'({pass, timeout, sync_lost}), 64'(3'b100));

        // three isolated errors in MEASURE
        set_default();
        flips = '{500, 1500, 2500};
        run_link(8000);
        check("t2_errs", 64'(err_count), 64'(3));
        check("t2_pass_max0", 64'(pass), 64'(0));
        check("t2_pass_max3", 64'(pass3), 64'(1));

        // frame sync never comes
        set_default();
        fs_hold_low = 1;
        run_link(3000);
        check("t3_wait_cycles", 64'(cnt_wait), 64'(1024));
        check("t3_flags", 64'({timeout, pass, done}), 64'(3'b101));
        check("t3_bits", 64'(bit_count), 64'(0));

        // sync drop at bit 100
        set_default();
        drop_at = 100;
        run_link(3000);
        check("t4_flags", 64'({sync_lost, pass, timeout}), 64'(3'b100));
        check("t4_bits", 64'(bit_count), 64'(100));

        // one bad bit in LOCK after 20 good: the flipped bit also spoils the predictions
        // 6 and 7 bits later, so lock completes 7+32 bits after it.
        set_default();
        lock_err_run = 20;
        run_link(8000);
        check("t5_lock_gap", 64'(lock_gap), 64'(39));
        check("t5_result", 64'({pass, err_count, bit_count}), 64'({1'b1, 16'd0, 16'd4096}));

        // abort in MEASURE, then a full restart
        set_default();
        abort_at = 1000;
        run_link(3000);
        check("t6_idle", 64'({state, pn_en, link_rst, busy, pass}), 64'(0));
        check("t6_no_done", 64'(cnt_done), 64'(0));
        check("t6_frozen_bits", 64'(bit_count), 64'(1000));
        set_default();
        run_link(8000);
        check("t6_restart", 64'({pass, bit_count, err_count}), 64'({1'b1, 16'd4096, 16'd0}));

        // reset in the middle of a test
        set_default();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (8) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("t7_rst_mid", 64'({state, busy, link_rst, pn_en, done}), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("t7_stays_idle", 64'({state, link_rst}), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
